mem_stage: RTL and testbench

- MEM stage of the 5-stage RV32 pipeline: the executing end of the memory command that the decode stage emits as `ID_mem_cmd` (`{store, funct3}`).
- Turns the EX/MEM command into a data-memory request/acknowledge transaction and drives the byte enables and replicated store data.
- Aligns and sign/zero-extends load data, and stalls upstream while a transaction is outstanding.
- Non-memory instructions pass their ALU result through to MEM/WB.

---
 rtl/mem_stage.sv | 187 ++++++++++++++++++
 tb/tb_mem_stage.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// MEM stage of the RV32 pipeline: data-memory req/ack transaction,
// byte-lane steering, load alignment/extension and upstream stall.
module mem_stage #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        EX_MEM_vld,
  input  logic [3:0]  EX_MEM_mem_cmd,
  input  logic [31:0] EX_MEM_alu_result,
  input  logic [31:0] EX_MEM_rs2_val,
  input  logic [4:0]  EX_MEM_rd,
  output logic        MEM_stall,
  output logic        proc2mem_req,
  output logic        proc2mem_we,
  output logic [31:0] proc2mem_addr,
  output logic [3:0]  proc2mem_be,
  output logic [31:0] proc2mem_wdata,
  input  logic        mem2proc_ack,
  input  logic [31:0] mem2proc_rdata,
  output logic        MEM_WB_vld,
  output logic [4:0]  MEM_WB_rd,
  output logic [31:0] MEM_WB_result,
  output logic        MEM_exc,
  output logic [1:0]  MEM_exc_cause,
  output logic [31:0] MEM_exc_addr
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [3:0] MEM_NONE = 4'hF;
  localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CW-1:0] TO_LAST =
    CW'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);

  state_t        state;
  logic [2:0]    f3_q;
  logic [1:0]    off_q;
  logic [CW-1:0] cnt;

  logic [2:0]  f3;
  logic [1:0]  a_lo;
  logic        is_none;
  logic        is_ld;
  logic        is_st;
  logic        legal;
  logic        misal;
  logic        go;
  logic        bad;
  logic        to_hit;
  logic [3:0]  be_n;
  logic [31:0] wdata_n;
  logic [31:0] sh;
  logic [31:0] ld_data;

  assign f3      = EX_MEM_mem_cmd[2:0];
  assign a_lo    = EX_MEM_alu_result[1:0];
  assign is_none = EX_MEM_mem_cmd == MEM_NONE;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    unique case (EX_MEM_mem_cmd)
      4'b0000, 4'b0001, 4'b0010,
      4'b0100, 4'b0101: is_ld = 1'b1;
      4'b1000, 4'b1001, 4'b1010: is_st = 1'b1;
      default: ;
    endcase
  end

  assign legal = is_ld | is_st;
  assign misal = (f3[1:0] == 2'b01 && a_lo[0])
              || (f3[1:0] == 2'b10 && a_lo != 2'b00);
  assign go    = EX_MEM_vld & legal & ~misal;
  assign bad   = EX_MEM_vld & ~is_none & (~legal | misal);

  always_comb begin
    be_n    = 4'hF;
    wdata_n = EX_MEM_rs2_val;
    unique case (f3[1:0])
      2'b00: begin
        be_n    = 4'b0001 << a_lo;
        wdata_n = {4{EX_MEM_rs2_val[7:0]}};
      end
      2'b01: begin
        be_n    = 4'b0011 << {a_lo[1], 1'b0};
        wdata_n = {2{EX_MEM_rs2_val[15:0]}};
      end
      default: ;
    endcase
  end

  assign sh = mem2proc_rdata >> {off_q, 3'b000};

  always_comb begin
    ld_data = sh;
    unique case (f3_q)
      3'b000:  ld_data = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ld_data = {{16{sh[15]}}, sh[15:0]};
      3'b100:  ld_data = {24'h0, sh[7:0]};
      3'b101:  ld_data = {16'h0, sh[15:0]};
      default: ;
    endcase
  end

  assign to_hit = (TIMEOUT_CYC != 0) && (cnt == TO_LAST);

  always_comb begin
    MEM_stall = 1'b0;
    unique case (state)
      IDLE:    MEM_stall = go;
      WAIT:    MEM_stall = ~mem2proc_ack & ~to_hit;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      f3_q           <= '0;
      off_q          <= '0;
      cnt            <= '0;
      proc2mem_req   <= 1'b0;
      proc2mem_we    <= 1'b0;
      proc2mem_addr  <= '0;
      proc2mem_be    <= '0;
      proc2mem_wdata <= '0;
      MEM_WB_vld     <= 1'b0;
      MEM_WB_rd      <= '0;
      MEM_WB_result  <= '0;
      MEM_exc        <= 1'b0;
      MEM_exc_cause  <= '0;
      MEM_exc_addr   <= '0;
    end else begin
      MEM_WB_vld <= 1'b0;
      MEM_exc    <= 1'b0;
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            go: begin
              state          <= WAIT;
              f3_q           <= f3;
              off_q          <= a_lo;
              cnt            <= '0;
              proc2mem_req   <= 1'b1;
              proc2mem_we    <= EX_MEM_mem_cmd[3];
              proc2mem_addr  <= {EX_MEM_alu_result[31:2], 2'b00};
              proc2mem_be    <= be_n;
              proc2mem_wdata <= wdata_n;
              MEM_WB_rd      <= EX_MEM_rd;
            end
            bad: begin
              MEM_exc       <= 1'b1;
              MEM_exc_cause <= legal ? 2'b01 : 2'b10;
              MEM_exc_addr  <= EX_MEM_alu_result;
            end
            EX_MEM_vld & is_none: begin
              MEM_WB_vld    <= 1'b1;
              MEM_WB_rd     <= EX_MEM_rd;
              MEM_WB_result <= EX_MEM_alu_result;
            end
            default: ;
          endcase
        end
        WAIT: begin
          // ack takes priority over a simultaneous timeout
          if (mem2proc_ack) begin
            state         <= IDLE;
            proc2mem_req  <= 1'b0;
            MEM_WB_vld    <= 1'b1;
            MEM_WB_result <= proc2mem_we ? 32'h0 : ld_data;
          end else if (to_hit) begin
            state         <= IDLE;
            proc2mem_req  <= 1'b0;
            MEM_exc       <= 1'b1;
            MEM_exc_cause <= 2'b11;
            MEM_exc_addr  <= {proc2mem_addr[31:2], off_q};
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized + directed bench for mem_stage against a byte-level
// reference model of RV32 load/store semantics.
module tb_mem_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        EX_MEM_vld;
  logic [3:0]  EX_MEM_mem_cmd;
  logic [31:0] EX_MEM_alu_result;
  logic [31:0] EX_MEM_rs2_val;
  logic [4:0]  EX_MEM_rd;
  logic        MEM_stall;
  logic        proc2mem_req;
  logic        proc2mem_we;
  logic [31:0] proc2mem_addr;
  logic [3:0]  proc2mem_be;
  logic [31:0] proc2mem_wdata;
  logic        mem2proc_ack;
  logic [31:0] mem2proc_rdata;
  logic        MEM_WB_vld;
  logic [4:0]  MEM_WB_rd;
  logic [31:0] MEM_WB_result;
  logic        MEM_exc;
  logic [1:0]  MEM_exc_cause;
  logic [31:0] MEM_exc_addr;

  int n_chk  = 0;
  int n_fail = 0;

  mem_stage #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk),
    .rst(rst),
    .EX_MEM_vld(EX_MEM_vld),
    .EX_MEM_mem_cmd(EX_MEM_mem_cmd),
    .EX_MEM_alu_result(EX_MEM_alu_result),
    .EX_MEM_rs2_val(EX_MEM_rs2_val),
    .EX_MEM_rd(EX_MEM_rd),
    .MEM_stall(MEM_stall),
    .proc2mem_req(proc2mem_req),
    .proc2mem_we(proc2mem_we),
    .proc2mem_addr(proc2mem_addr),
    .proc2mem_be(proc2mem_be),
    .proc2mem_wdata(proc2mem_wdata),
    .mem2proc_ack(mem2proc_ack),
    .mem2proc_rdata(mem2proc_rdata),
    .MEM_WB_vld(MEM_WB_vld),
    .MEM_WB_rd(MEM_WB_rd),
    .MEM_WB_result(MEM_WB_result),
    .MEM_exc(MEM_exc),
    .MEM_exc_cause(MEM_exc_cause),
    .MEM_exc_addr(MEM_exc_addr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_legal(input logic [3:0] c);
    return c inside {4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA};
  endfunction

  function automatic logic [3:0] m_be(input int n, input logic [31:0] a);
    int v;
    v = ((1 << n) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] m_wdata(input int n, input logic [31:0] d);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % n) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [31:0] a,
                                         input logic [31:0] d);
    int n;
    logic [31:0] v;
    logic [31:0] mask;
    n = 1 << f3[1:0];
    v = d >> (8 * (a % 4));
    if (n < 4) begin
      mask = (32'h1 << (8 * n)) - 32'h1;
      v = v & mask;
      if (!f3[2] && v[8*n-1]) v = v | ~mask;
    end
    return v;
  endfunction

  task automatic run_op(input logic [3:0] cmd, input logic [31:0] a,
                        input logic [31:0] rs2, input logic [4:0] rd,
                        input int lat, input logic [31:0] rdata);
    int n;
    int k;
    int stalls;
    bit done;
    n = 1 << cmd[1:0];
    @(negedge clk);
    EX_MEM_vld = 1'b1;
    EX_MEM_mem_cmd = cmd;
    EX_MEM_alu_result = a;
    EX_MEM_rs2_val = rs2;
    EX_MEM_rd = rd;
    mem2proc_ack = 1'b0;
    #1;
    if (cmd == 4'hF) begin
      chk("alu_stall", 32'(MEM_stall), 0);
      @(negedge clk);
      EX_MEM_vld = 1'b0;
      chk("alu_vld", 32'(MEM_WB_vld), 1);
      chk("alu_result", MEM_WB_result, a);
      chk("alu_rd", 32'(MEM_WB_rd), 32'(rd));
      chk("alu_exc", 32'(MEM_exc), 0);
    end else if (!m_legal(cmd) || (a % n) != 0) begin
      chk("bad_stall", 32'(MEM_stall), 0);
      chk("bad_noreq", 32'(proc2mem_req), 0);
      @(negedge clk);
      EX_MEM_vld = 1'b0;
      chk("bad_exc", 32'(MEM_exc), 1);
      chk("bad_cause", 32'(MEM_exc_cause), m_legal(cmd) ? 1 : 2);
      chk("bad_addr", MEM_exc_addr, a);
      chk("bad_wbvld", 32'(MEM_WB_vld), 0);
      chk("bad_noreq2", 32'(proc2mem_req), 0);
      @(negedge clk);
      chk("bad_pulse", 32'(MEM_exc), 0);
    end else begin
      chk("mem_stall0", 32'(MEM_stall), 1);
      stalls = 1;
      @(negedge clk);
      chk("mem_req", 32'(proc2mem_req), 1);
      chk("mem_we", 32'(proc2mem_we), 32'(cmd[3]));
      chk("mem_addr", proc2mem_addr, a & 32'hFFFF_FFFC);
      chk("mem_be", 32'(proc2mem_be), 32'(m_be(n, a)));
      if (cmd[3]) chk("mem_wdata", proc2mem_wdata, m_wdata(n, rs2));
      done = 1'b0;
      k = 1;
      while (!done) begin
        if (k == lat) begin
          mem2proc_ack = 1'b1;
          mem2proc_rdata = rdata;
        end
        #1;
        if (k == lat || k == TO) chk("mem_release", 32'(MEM_stall), 0);
        else begin
          chk("mem_hold", 32'(MEM_stall), 1);
          chk("mem_req_hold", 32'(proc2mem_req), 1);
          stalls++;
        end
        if (k == lat || k == TO) begin
          @(negedge clk);
          mem2proc_ack = 1'b0;
          mem2proc_rdata = $urandom;
          EX_MEM_vld = 1'b0;
          chk("mem_reqdrop", 32'(proc2mem_req), 0);
          if (k == lat) begin
            chk("mem_wbvld", 32'(MEM_WB_vld), 1);
            chk("mem_result", MEM_WB_result,
                cmd[3] ? 32'h0 : m_load(cmd[2:0], a, rdata));
            chk("mem_rd", 32'(MEM_WB_rd), 32'(rd));
            chk("mem_noexc", 32'(MEM_exc), 0);
          end else begin
            chk("to_exc", 32'(MEM_exc), 1);
            chk("to_cause", 32'(MEM_exc_cause), 3);
            chk("to_addr", MEM_exc_addr, a);
            chk("to_wbvld", 32'(MEM_WB_vld), 0);
          end
          done = 1'b1;
        end else begin
          @(negedge clk);
          k++;
        end
      end
      chk("mem_stalls", stalls, (lat < TO) ? lat : TO);
    end
  endtask

  initial begin
    logic [3:0] codes [9];
    logic [3:0] c;
    logic [31:0] a;
    codes = '{4'h0, 4'h1, 4'h2, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hF};
    rst = 1'b0;
    EX_MEM_vld = 1'b0;
    EX_MEM_mem_cmd = 4'hF;
    EX_MEM_alu_result = '0;
    EX_MEM_rs2_val = '0;
    EX_MEM_rd = '0;
    mem2proc_ack = 1'b0;
    mem2proc_rdata = '0;
    #12;
    chk("rst_req", 32'(proc2mem_req), 0);
    chk("rst_addr", proc2mem_addr, 0);
    chk("rst_be", 32'(proc2mem_be), 0);
    chk("rst_wbvld", 32'(MEM_WB_vld), 0);
    chk("rst_result", MEM_WB_result, 0);
    chk("rst_exc", 32'(MEM_exc), 0);
    chk("rst_stall", 32'(MEM_stall), 0);
    @(negedge clk);
    rst = 1'b1;

    run_op(4'h2, 32'h104, 32'h0, 5'd3, 2, 32'hDEADBEEF);
    run_op(4'h0, 32'h103, 32'h0, 5'd4, 1, 32'h80112233);
    run_op(4'h4, 32'h103, 32'h0, 5'd5, 1, 32'h80112233);
    run_op(4'h9, 32'h202, 32'h1234ABCD, 5'd6, 1, 32'h0);
    run_op(4'h2, 32'h101, 32'h0, 5'd7, 1, 32'h0);
    run_op(4'h3, 32'h100, 32'h0, 5'd8, 1, 32'h0);
    run_op(4'h1, 32'h40, 32'h0, 5'd9, 9, 32'h0);
    run_op(4'hA, 32'h44, 32'h55AA, 5'd10, TO, 32'h0);

    @(negedge clk);
    EX_MEM_vld = 1'b1;
    EX_MEM_mem_cmd = 4'h2;
    EX_MEM_alu_result = 32'h300;
    @(negedge clk);
    EX_MEM_vld = 1'b0;
    chk("rw_req", 32'(proc2mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("rw_reqdrop", 32'(proc2mem_req), 0);
    chk("rw_stall", 32'(MEM_stall), 0);
    @(negedge clk);
    rst = 1'b1;
    mem2proc_ack = 1'b1;
    @(negedge clk);
    mem2proc_ack = 1'b0;
    chk("rw_ackidle_vld", 32'(MEM_WB_vld), 0);
    chk("rw_ackidle_req", 32'(proc2mem_req), 0);
    run_op(4'hF, 32'h5, 32'h0, 5'd1, 1, 32'h0);

    for (int i = 0; i < 60; i++) begin
      c = ($urandom_range(0, 3) == 0) ? 4'($urandom) : codes[$urandom_range(0, 8)];
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      run_op(c, a, $urandom, 5'($urandom), $urandom_range(1, 6), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
